// File: rtl/life_seed_fill.sv
// life_seed_fill: fills the life-engine frame buffer with a clear, set or
// pseudo-random pattern. It writes one byte at a time through a req/ack port
// to the SRAM slot arbiter.
// Optional build macro: LIFE_SEED_BORDER_EN. When it is defined, the outermost
// ring of cells is masked to dead.
module life_seed_fill #(
    parameter int          BYTES_PER_ROW = 200,
    parameter int          ROWS          = 1200,
    parameter logic [31:0] SEED          = 32'h00000001
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [1:0]  density,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack
);

    localparam int          TOTAL     = BYTES_PER_ROW * ROWS;
    localparam logic [18:0] LAST_ADDR = 19'(TOTAL - 1);
    localparam int          COL_W     = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
    localparam int          ROW_W     = $clog2(ROWS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTES_PER_ROW - 1);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [1:0]       density_q;
    logic [31:0]      lfsr_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [18:0]      addr_q;
    logic [7:0]       wdata_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;

    logic             ack_fire;
    logic [31:0]      lfsr_step;
    logic [31:0]      lfsr_d;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;

    // Raw pattern byte for a mode/density, given the low 24 LFSR bits.
    function automatic logic [7:0] pattern_byte(input logic [1:0] m, input logic [1:0] d,
                                                input logic [23:0] l);
        logic [7:0] b;
        b = 8'h00;
        case (m)
            2'b01: b = 8'hFF;
            2'b10: begin
                case (d)
                    2'b00:   b = l[7:0];
                    2'b01:   b = l[7:0] & l[15:8];
                    2'b10:   b = l[7:0] & l[15:8] & l[23:16];
                    default: b = l[7:0] | l[15:8];
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef LIFE_SEED_BORDER_EN
    // Keep the outermost cell ring dead. Bit 7 is the leftmost pixel of a byte.
    function automatic logic [7:0] border_mask(input logic [7:0] b, input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
        logic [7:0] o;
        o = b;
        if (r == '0 || r == ROW_W'(ROWS - 1)) begin
            o = 8'h00;
        end else if (c == '0) begin
            o = b & 8'h7F;
        end else if (c == COL_LAST) begin
            o = b & 8'hFE;
        end
        return o;
    endfunction

    function automatic logic [7:0] fill_byte(input logic [1:0] m, input logic [1:0] d,
                                             input logic [23:0] l, input logic [ROW_W-1:0] r,
                                             input logic [COL_W-1:0] c);
        return border_mask(pattern_byte(m, d, l), r, c);
    endfunction
`else
    function automatic logic [7:0] fill_byte(input logic [1:0] m, input logic [1:0] d,
                                             input logic [23:0] l);
        return pattern_byte(m, d, l);
    endfunction
`endif

    // Handshake qualification, LFSR advance and row/col wrap for the next byte.
    always_comb begin
        ack_fire  = (state_q == S_FILL) && req_q && mem_ack;
        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        lfsr_d    = (ack_fire && mode_q == 2'b10) ? lfsr_step : lfsr_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
            row_d = row_q;
        end
    end

    // Fill FSM with all outputs registered.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            density_q <= 2'b00;
            lfsr_q    <= SEED_EFF;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FILL;
                        mode_q    <= mode;
                        density_q <= density;
                        addr_q    <= '0;
                        col_q     <= '0;
                        row_q     <= '0;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef LIFE_SEED_BORDER_EN
                        wdata_q   <= fill_byte(mode, density, lfsr_q[23:0], '0, '0);
`else
                        wdata_q   <= fill_byte(mode, density, lfsr_q[23:0]);
`endif
                    end
                end
                default: begin
                    // An ack that coincides with abort still counts as written.
                    lfsr_q <= lfsr_d;
                    if (ack_fire) begin
                        addr_q <= addr_q + 19'd1;
                        col_q  <= col_d;
                        row_q  <= row_d;
`ifdef LIFE_SEED_BORDER_EN
                        wdata_q <= fill_byte(mode_q, density_q, lfsr_d[23:0], row_d, col_d);
`else
                        wdata_q <= fill_byte(mode_q, density_q, lfsr_d[23:0]);
`endif
                    end
                    if (abort) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (ack_fire && addr_q == LAST_ADDR) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_life_seed_fill.sv
// Self-checking bench for life_seed_fill on a 4x3-byte frame buffer.
module tb_life_seed_fill;

    localparam int BPR  = 4;
    localparam int ROWS = 3;
    localparam int N    = BPR * ROWS;

    logic        clk_pixel = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic [1:0]  mode      = 2'b00;
    logic [1:0]  density   = 2'b00;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack   = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_lfsr = 32'd1;

    always #5 clk_pixel = ~clk_pixel;

    life_seed_fill #(.BYTES_PER_ROW(BPR), .ROWS(ROWS), .SEED(32'h00000001)) dut (
        .clk_pixel(clk_pixel),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .density(density),
        .busy(busy),
        .done(done),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Galois LFSR, right shift, taps 0x80200003.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    endfunction

    // Expected byte at a given address for the given mode/density and LFSR state.
    function automatic logic [7:0] ref_byte(input int m, input int d, input int a,
                                            input logic [31:0] l);
        int r;
        int c;
        logic [7:0] b;
        r = a / BPR;
        c = a % BPR;
        if (m == 1) b = 8'hFF;
        else if (m == 2) begin
            if (d == 0)      b = l[7:0];
            else if (d == 1) b = l[7:0] & l[15:8];
            else if (d == 2) b = l[7:0] & l[15:8] & l[23:16];
            else             b = l[7:0] | l[15:8];
        end else b = 8'h00;
`ifdef LIFE_SEED_BORDER_EN
        if (r == 0 || r == ROWS - 1) b = 8'h00;
        else if (c == 0)             b = b & 8'h7F;
        else if (c == BPR - 1)       b = b & 8'hFE;
`else
        if (r < 0 || c < 0) b = 8'h00;
`endif
        return b;
    endfunction

    // policy: 0 = ack every cycle, 1 = ack every third cycle, 2 = random ack.
    task automatic run_fill(input int m, input int d, input int policy, input int abort_after,
                            input bit mid_start, input bit abort_at_start);
        int exp_addr;
        int acks;
        bit finished;
        bit prev_stall;
        bit ack;
        bit ab;
        logic [18:0] prev_addr;
        logic [7:0]  prev_wdata;
        logic [7:0]  exp_b;
        exp_addr = 0;
        acks = 0;
        finished = 0;
        prev_stall = 0;
        prev_addr = '0;
        prev_wdata = '0;
        @(negedge clk_pixel);
        mode = 2'(m);
        density = 2'(d);
        start = 1'b1;
        abort = abort_at_start;
        @(negedge clk_pixel);
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", busy, 1);
        check("req_after_start", mem_req, 1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (prev_stall) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (policy == 0)      ack = 1'b1;
            else if (policy == 1) ack = (cyc % 3 == 2);
            else                  ack = ($urandom_range(0, 1) == 1);
            ab = (abort_after >= 0 && acks == abort_after);
            mem_ack = ack;
            abort = ab;
            if (mid_start && cyc == 3) begin
                start = 1'b1;
                mode = 2'(m) ^ 2'b01;
            end
            if (ack) begin
                exp_b = ref_byte(m, d, exp_addr, ref_lfsr);
                $display("write addr=%0d data=0x%02h expect addr=%0d data=0x%02h",
                         mem_addr, mem_wdata, exp_addr, exp_b);
                check("addr", mem_addr, exp_addr);
                check("wdata", mem_wdata, exp_b);
                if (m == 2) ref_lfsr = lfsr_next(ref_lfsr);
                exp_addr++;
                acks++;
            end
            prev_stall = !ack;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
            @(negedge clk_pixel);
            mem_ack = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            if (ab) begin
                check("abort_req", mem_req, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                finished = 1;
            end else if (exp_addr == N) begin
                check("final_done", done, 1);
                check("final_busy", busy, 0);
                check("final_req", mem_req, 0);
                @(negedge clk_pixel);
                check("done_one_cycle", done, 0);
                finished = 1;
            end else begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
            end
        end
        if (!finished) check("fill_timeout", 0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_pixel);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        ref_lfsr = 32'd1;

        // Random from seed 1, continuous ack: 0x01 then 0x03
        run_fill(2, 0, 0, -1, 0, 0);
        // Set pattern, continuous ack
        run_fill(1, 0, 0, -1, 0, 0);
        // Random density 01, ack every third cycle
        run_fill(2, 1, 1, -1, 0, 0);
        // Abort after 5 acks (abort coincides with the 6th ack)
        run_fill(2, 3, 0, 5, 0, 0);
        // Restart continues the LFSR
        run_fill(2, 2, 2, -1, 0, 0);
        // Start pulsed mid-fill is ignored
        run_fill(1, 0, 0, -1, 1, 0);
        // Mode 11 behaves as clear
        run_fill(3, 0, 2, -1, 0, 0);
        // Start and abort together in IDLE: start wins
        run_fill(1, 0, 2, -1, 0, 1);

        // Abort and ack while idle have no effect
        @(negedge clk_pixel);
        abort = 1'b1;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk_pixel);
        check("idle_abort_busy", busy, 0);
        check("idle_ack_req", mem_req, 0);
        abort = 1'b0;
        mem_ack = 1'b0;
        run_fill(2, 0, 0, -1, 0, 0);

        // Reset mid-fill reseeds the LFSR
        @(negedge clk_pixel);
        mode = 2'b10;
        density = 2'b00;
        start = 1'b1;
        @(negedge clk_pixel);
        start = 1'b0;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk_pixel);
        mem_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk_pixel);
        check("midrst_busy", busy, 0);
        check("midrst_req", mem_req, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        ref_lfsr = 32'd1;
        run_fill(2, 0, 0, -1, 0, 0);

        // Randomized fills
        for (int i = 0; i < 6; i++) begin
            run_fill(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                     0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_seed_fill.md
Name: life_seed_fill

Overview:
- Frame-buffer initialiser that sits upstream of the life engine in the clk_pixel domain.
- Writes every byte of the SRAM frame buffer with a clear, set or pseudo-random pattern; the engine then reads this as generation 0.
- Issues one byte write at a time to the SRAM slot arbiter through a req/ack handshake.
- The arbiter only acks while the engine is stopped; this block does not check run state.

Parameters:
- BYTES_PER_ROW, 200, bytes per display row (H_ACTIVE/8, 8 pixels per byte, bit 7 = leftmost pixel)
- ROWS, 1200, display rows (V_ACTIVE)
- SEED, 32'h00000001, LFSR reset value; 0 is replaced by 1

Ports:
- clk_pixel  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  single-cycle pulse, begins a fill; honoured only in IDLE
- abort  in  1  level/pulse, terminates a fill in progress
- mode  in  2  00 clear (0x00), 01 set (0xFF), 10 random, 11 treated as clear; sampled on accepted start
- density  in  2  random mode only; sampled on accepted start
- busy  out  1  high in FILL
- done  out  1  one-cycle pulse after the final byte is acked
- mem_req  out  1  write request to arbiter
- mem_addr  out  19  byte address
- mem_wdata  out  8  byte to write
- mem_ack  in  1  arbiter accepted current byte this cycle; ignored when mem_req low

Behaviour:
- Reset (rst_n low at clock edge):
  - state IDLE; busy, done, mem_req = 0; mem_addr = 0; mem_wdata = 0.
  - row/col counters = 0; LFSR = SEED (1 if SEED == 0).
- States: IDLE, FILL.
- IDLE -> FILL on start:
  - latch mode and density; addr, row and col = 0.
  - mem_req and busy go high the next cycle, with mem_wdata valid for address 0.
- Handshake:
  - mem_addr and mem_wdata are held stable while mem_req is high and mem_ack is low.
  - On the ack cycle: addr += 1 and col += 1; when col == BYTES_PER_ROW-1, col wraps to 0 and row += 1.
  - Next byte is presented the following cycle. mem_req may stay high continuously, giving 1 byte/cycle with continuous ack.
- LFSR:
  - 32-bit Galois, right shift; if bit0 is 1, XOR 32'h80200003.
  - Advances exactly once per ack, in random mode only. It is never reseeded except by reset, so successive random fills differ.
- Random byte L = current LFSR state:
  - density 00: L[7:0] (50%)
  - density 01: L[7:0] & L[15:8] (25%)
  - density 10: L[7:0] & L[15:8] & L[23:16] (12.5%)
  - density 11: L[7:0] | L[15:8] (75%)
- Completion:
  - Final byte is address BYTES_PER_ROW*ROWS-1.
  - On its ack, the next cycle has state IDLE, mem_req = 0, busy = 0, and done = 1 for exactly one cycle.
- abort:
  - In FILL, next cycle: IDLE, mem_req = 0, busy = 0, done = 0.
  - An ack in the same cycle as abort still counts as written (LFSR advances), but no further requests are issued.
  - In IDLE, abort has no effect.
- start while busy: ignored.
- start and abort in the same IDLE cycle: start wins.
- mem_ack with mem_req low: ignored.
- Reset mid-fill: immediate return to IDLE with all reset values, including LFSR = SEED.

Optional Feature:
- Macro: LIFE_SEED_BORDER_EN.
- Defined: mem_wdata is masked so the outermost cell ring stays dead.
  - row 0 or row ROWS-1: 0x00
  - else col 0: & 0x7F
  - else col BYTES_PER_ROW-1: & 0xFE
  - Masking applies to all modes; LFSR stepping is unchanged.
- Undefined: no masking, and no row/col comparison logic is synthesised beyond what the wrap counter needs.

Test Plan:
- BYTES_PER_ROW=4, ROWS=3, mode 01, ack tied high -> 12 writes, addr 0..11 ascending, all 0xFF; done pulses 1 cycle after ack of addr 11; busy low the same cycle.
- Reset, SEED=1, mode 10, density 00, continuous ack -> wdata 0x01 at addr 0, then 0x03 at addr 1.
- Ack asserted every third cycle -> addr/wdata held constant during stalls; 12 writes total, no duplicates or skips.
- abort after 5 acks -> mem_req low next cycle, no done, busy 0; a new start restarts at addr 0 with the LFSR continuing, not reseeded.
- start pulsed mid-fill -> ignored; address sequence and mode unchanged.
- LIFE_SEED_BORDER_EN defined, mode 01, 4x3 -> row 0 and row 2 bytes = 0x00; row 1 = 0x7F, 0xFF, 0xFF, 0xFE.
